// File: rtl/Purple_Jade_pkg.sv
// Shared types and default timing parameters for the branch-mispredict recovery sequencer.
package Purple_Jade_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        DRAIN    = 3'd2,
        RESTORE  = 3'd3,
        REDIRECT = 3'd4
    } recovery_state_e;

    localparam int RECOVERY_FLUSH_CYCLES  = 2;
    localparam int RECOVERY_DRAIN_TIMEOUT = 64;

    // Width able to hold values 0..max(a,b)
    function automatic int recovery_cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/mispredict_recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/mispredict_recovery_ctrl.sv
// Commit-time branch-mispredict recovery sequencer: flush, drain, rename rollback, fetch redirect.
// Optional performance counters are enabled by defining RECOVERY_PERF_CNT_EN.
module mispredict_recovery_ctrl
    import Purple_Jade_pkg::*;
#(
    parameter int WORD_SIZE_P   = 32,
    parameter int FLUSH_CYCLES  = RECOVERY_FLUSH_CYCLES,
    parameter int DRAIN_TIMEOUT = RECOVERY_DRAIN_TIMEOUT
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   mispredict_v_i,
    input  logic [WORD_SIZE_P-1:0] mispredict_pc_i,
    input  logic                   rob_empty_i,
    input  logic                   sb_pending_i,
    input  logic                   fu_busy_i,
    input  logic                   fetch_ready_i,
    output logic                   flush_o,
    output logic                   decode_hold_o,
    output logic                   rename_rollback_o,
    output logic                   redirect_v_o,
    output logic [WORD_SIZE_P-1:0] redirect_pc_o,
    output logic                   recovering_o,
    output logic                   drain_timeout_o
`ifdef RECOVERY_PERF_CNT_EN
    ,
    output logic [31:0]            perf_recoveries_o,
    output logic [31:0]            perf_stall_cycles_o
`endif
);

    localparam int CNT_W = recovery_cnt_width(FLUSH_CYCLES, DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    recovery_state_e        r_state;
    recovery_state_e        w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [WORD_SIZE_P-1:0] r_pc;
    logic                   r_drain_timeout;
    logic                   w_drain_ok;
    logic                   w_drain_expired;
    logic                   w_start;

    assign w_drain_ok      = rob_empty_i & ~sb_pending_i & ~fu_busy_i;
    assign w_drain_expired = (r_state == DRAIN) & ~w_drain_ok & (r_cnt == DRAIN_LAST);
    assign w_start         = (r_state == IDLE) & mispredict_v_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cnt restarts on every state change, so FLUSH and DRAIN each start from zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt           <= '0;
            r_pc            <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (((r_state == FLUSH) || (r_state == DRAIN)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_start) begin
                r_pc <= mispredict_pc_i;
            end
            if (w_drain_expired) begin
                r_drain_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (mispredict_v_i) w_state_next = FLUSH;
            FLUSH:    if (r_cnt == FLUSH_LAST) w_state_next = DRAIN;
            DRAIN:    if (w_drain_ok || w_drain_expired) w_state_next = RESTORE;
            RESTORE:  w_state_next = REDIRECT;
            REDIRECT: if (fetch_ready_i) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        flush_o           = 1'b0;
        decode_hold_o     = 1'b0;
        rename_rollback_o = 1'b0;
        redirect_v_o      = 1'b0;
        redirect_pc_o     = '0;
        recovering_o      = (r_state != IDLE);
        drain_timeout_o   = r_drain_timeout;
        case (r_state)
            FLUSH: begin
                flush_o       = 1'b1;
                decode_hold_o = 1'b1;
            end
            DRAIN: begin
                decode_hold_o = 1'b1;
            end
            RESTORE: begin
                rename_rollback_o = 1'b1;
                decode_hold_o     = 1'b1;
            end
            REDIRECT: begin
                redirect_v_o  = 1'b1;
                redirect_pc_o = r_pc;
                decode_hold_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef RECOVERY_PERF_CNT_EN
    logic w_stall_inc;
    assign w_stall_inc = (r_state != IDLE);

    sat_counter #(.WIDTH(32)) u_perf_recoveries (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (w_start),
        .clr_i   (1'b0),
        .count_o (perf_recoveries_o)
    );

    sat_counter #(.WIDTH(32)) u_perf_stall_cycles (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (w_stall_inc),
        .clr_i   (1'b0),
        .count_o (perf_stall_cycles_o)
    );
`else
    // Base build: no performance counters.
`endif

endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
// Self-checking bench for mispredict_recovery_ctrl: vector table plus hand-written corner sequences.
module tb_mispredict_recovery_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        mispredict_v_i;
    logic [31:0] mispredict_pc_i;
    logic        rob_empty_i;
    logic        sb_pending_i;
    logic        fu_busy_i;
    logic        fetch_ready_i;
    logic        flush_o;
    logic        decode_hold_o;
    logic        rename_rollback_o;
    logic        redirect_v_o;
    logic [31:0] redirect_pc_o;
    logic        recovering_o;
    logic        drain_timeout_o;
`ifdef RECOVERY_PERF_CNT_EN
    logic [31:0] perf_recoveries_o;
    logic [31:0] perf_stall_cycles_o;
`endif

    always #5 clk_i = ~clk_i;

    mispredict_recovery_ctrl #(
        .WORD_SIZE_P   (32),
        .FLUSH_CYCLES  (2),
        .DRAIN_TIMEOUT (64)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .mispredict_v_i    (mispredict_v_i),
        .mispredict_pc_i   (mispredict_pc_i),
        .rob_empty_i       (rob_empty_i),
        .sb_pending_i      (sb_pending_i),
        .fu_busy_i         (fu_busy_i),
        .fetch_ready_i     (fetch_ready_i),
        .flush_o           (flush_o),
        .decode_hold_o     (decode_hold_o),
        .rename_rollback_o (rename_rollback_o),
        .redirect_v_o      (redirect_v_o),
        .redirect_pc_o     (redirect_pc_o),
        .recovering_o      (recovering_o),
        .drain_timeout_o   (drain_timeout_o)
`ifdef RECOVERY_PERF_CNT_EN
        ,
        .perf_recoveries_o   (perf_recoveries_o),
        .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        mp;
        logic [31:0] pc;
        logic        rob;
        logic        sb;
        logic        fu;
        logic        fr;
    } in_t;

    typedef struct packed {
        logic        flush;
        logic        hold;
        logic        rb;
        logic        rv;
        logic [31:0] rpc;
        logic        rec;
        logic        dto;
    } exp_t;

    typedef struct {
        in_t  vin;
        exp_t e;
    } vec_t;

    localparam int S_IDLE = 0, S_FLUSH = 1, S_DRAIN = 2, S_RESTORE = 3, S_REDIRECT = 4;
    localparam logic [31:0] P1 = 32'h0000_1040;
    localparam logic [31:0] P2 = 32'h0000_ABC0;
    localparam logic [31:0] P3 = 32'h0000_3000;
    localparam logic [31:0] P5 = 32'h0000_2000;
    localparam logic [31:0] PD = 32'hDEAD_0000;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic in_t mk_in(logic rst, logic mp, logic [31:0] pc,
                                  logic rob, logic sb, logic fu, logic fr);
        in_t v;
        v.rst = rst; v.mp = mp; v.pc = pc; v.rob = rob; v.sb = sb; v.fu = fu; v.fr = fr;
        return v;
    endfunction

    // Expected Moore outputs for a given recovery phase.
    function automatic exp_t ex(int st, logic [31:0] pc, logic dto);
        exp_t e;
        e.flush = (st == S_FLUSH);
        e.hold  = (st != S_IDLE);
        e.rb    = (st == S_RESTORE);
        e.rv    = (st == S_REDIRECT);
        e.rpc   = (st == S_REDIRECT) ? pc : 32'h0;
        e.rec   = (st != S_IDLE);
        e.dto   = dto;
        return e;
    endfunction

    function automatic vec_t vv(in_t i, exp_t e);
        vec_t r;
        r.vin = i;
        r.e   = e;
        return r;
    endfunction

    task automatic check(input string name);
        exp_t e;
        exp_t a;
        e = sb_q.pop_front();
        a = {flush_o, decode_hold_o, rename_rollback_o, redirect_v_o,
             redirect_pc_o, recovering_o, drain_timeout_o};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end else begin
            $display("[TB] %s ok rec=%b hold=%b rb=%b rv=%b pc=%h dto=%b",
                     name, a.rec, a.hold, a.rb, a.rv, a.rpc, a.dto);
        end
    endtask

    task automatic step(input in_t v, input exp_t e, input string name);
        @(negedge clk_i);
        reset_i         = v.rst;
        mispredict_v_i  = v.mp;
        mispredict_pc_i = v.pc;
        rob_empty_i     = v.rob;
        sb_pending_i    = v.sb;
        fu_busy_i       = v.fu;
        fetch_ready_i   = v.fr;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        check(name);
    endtask

    in_t idle_in;

    initial begin
        idle_in = mk_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        reset_i = 1'b1; mispredict_v_i = 1'b1; mispredict_pc_i = P1;
        rob_empty_i = 1'b1; sb_pending_i = 1'b0; fu_busy_i = 1'b0; fetch_ready_i = 1'b1;

        // 1: reset held with a pending mispredict
        for (int i = 0; i < 3; i++)
            step(mk_in(1'b1, 1'b1, P1, 1'b1, 1'b0, 1'b0, 1'b1), ex(S_IDLE, 0, 1'b0), "reset_hold");
        step(idle_in, ex(S_IDLE, 0, 1'b0), "reset_release");

        // 2: vector table (clean recovery, drain stalls, fetch backpressure, back-to-back)
        tbl.push_back(vv(mk_in(0, 1, P1, 1, 0, 0, 1), ex(S_FLUSH,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_FLUSH,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_DRAIN,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_RESTORE,  0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_REDIRECT, P1, 0)));
        tbl.push_back(vv(idle_in,                     ex(S_IDLE,     0,  0)));
        tbl.push_back(vv(mk_in(0, 1, P2, 1, 0, 0, 1), ex(S_FLUSH,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_FLUSH,    0,  0)));
        tbl.push_back(vv(mk_in(0, 0, 0, 1, 1, 0, 1),  ex(S_DRAIN,    0,  0)));
        tbl.push_back(vv(mk_in(0, 0, 0, 1, 1, 0, 1),  ex(S_DRAIN,    0,  0)));
        tbl.push_back(vv(mk_in(0, 0, 0, 1, 0, 1, 1),  ex(S_DRAIN,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_RESTORE,  0,  0)));
        tbl.push_back(vv(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_REDIRECT, P2, 0)));
        tbl.push_back(vv(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_REDIRECT, P2, 0)));
        tbl.push_back(vv(mk_in(0, 1, PD, 1, 0, 0, 1), ex(S_IDLE,     0,  0)));
        tbl.push_back(vv(mk_in(0, 1, P3, 1, 0, 0, 1), ex(S_FLUSH,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_FLUSH,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_DRAIN,    0,  0)));
        tbl.push_back(vv(mk_in(0, 0, 0, 0, 0, 0, 1),  ex(S_DRAIN,    0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_RESTORE,  0,  0)));
        tbl.push_back(vv(idle_in,                     ex(S_REDIRECT, P3, 0)));
        tbl.push_back(vv(idle_in,                     ex(S_IDLE,     0,  0)));
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].vin, tbl[i].e, $sformatf("vec%0d", i));

        // 3: ROB not empty for 10 DRAIN cycles
        step(mk_in(0, 1, P1, 0, 0, 0, 1), ex(S_FLUSH, 0, 0), "rob_flush");
        step(mk_in(0, 0, 0, 0, 0, 0, 1),  ex(S_FLUSH, 0, 0), "rob_flush");
        step(mk_in(0, 0, 0, 0, 0, 0, 1),  ex(S_DRAIN, 0, 0), "rob_drain_enter");
        for (int i = 0; i < 10; i++)
            step(mk_in(0, 0, 0, 0, 0, 0, 1), ex(S_DRAIN, 0, 0), "rob_drain_wait");
        step(idle_in, ex(S_RESTORE,  0,  0), "rob_restore");
        step(idle_in, ex(S_REDIRECT, P1, 0), "rob_redirect");
        step(idle_in, ex(S_IDLE,     0,  0), "rob_idle");

        // 4: FU stuck busy forces the drain timeout
        step(mk_in(0, 1, P1, 1, 0, 1, 1), ex(S_FLUSH, 0, 0), "to_flush");
        step(mk_in(0, 0, 0, 1, 0, 1, 1),  ex(S_FLUSH, 0, 0), "to_flush");
        step(mk_in(0, 0, 0, 1, 0, 1, 1),  ex(S_DRAIN, 0, 0), "to_drain_enter");
        for (int i = 0; i < 63; i++)
            step(mk_in(0, 0, 0, 1, 0, 1, 1), ex(S_DRAIN, 0, 0), "to_drain_wait");
        step(mk_in(0, 0, 0, 1, 0, 1, 1), ex(S_RESTORE,  0,  1), "to_restore");
        step(idle_in,                    ex(S_REDIRECT, P1, 1), "to_redirect");
        step(idle_in,                    ex(S_IDLE,     0,  1), "to_idle");
        step(mk_in(0, 1, P2, 1, 0, 0, 1), ex(S_FLUSH, 0, 1), "sticky_flush");
        step(idle_in, ex(S_FLUSH,    0,  1), "sticky_flush");
        step(idle_in, ex(S_DRAIN,    0,  1), "sticky_drain");
        step(idle_in, ex(S_RESTORE,  0,  1), "sticky_restore");
        step(idle_in, ex(S_REDIRECT, P2, 1), "sticky_redirect");
        step(idle_in, ex(S_IDLE,     0,  1), "sticky_idle");

        // 5: stale mispredict during DRAIN, then fetch backpressure
        step(mk_in(0, 1, P1, 0, 0, 0, 0), ex(S_FLUSH, 0, 1), "stale_flush");
        step(mk_in(0, 0, 0, 0, 0, 0, 0),  ex(S_FLUSH, 0, 1), "stale_flush");
        step(mk_in(0, 0, 0, 0, 0, 0, 0),  ex(S_DRAIN, 0, 1), "stale_drain");
        step(mk_in(0, 1, P5, 0, 0, 0, 0), ex(S_DRAIN, 0, 1), "stale_mp_ignored");
        step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_RESTORE, 0, 1), "stale_restore");
        step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_REDIRECT, P1, 1), "stale_redirect");
        for (int i = 0; i < 5; i++)
            step(mk_in(0, 0, 0, 1, 0, 0, 0), ex(S_REDIRECT, P1, 1), "redirect_hold");
        step(idle_in, ex(S_IDLE, 0, 1), "redirect_done");

        // 6: reset during RESTORE aborts with no redirect
        step(mk_in(0, 1, P3, 1, 0, 0, 1), ex(S_FLUSH, 0, 1), "abort_flush");
        step(idle_in, ex(S_FLUSH,   0, 1), "abort_flush");
        step(idle_in, ex(S_DRAIN,   0, 1), "abort_drain");
        step(idle_in, ex(S_RESTORE, 0, 1), "abort_restore");
        step(mk_in(1, 0, 0, 1, 0, 0, 1), ex(S_IDLE, 0, 0), "abort_reset");
        for (int i = 0; i < 3; i++)
            step(idle_in, ex(S_IDLE, 0, 0), "abort_quiet");

        // Two back-to-back recoveries, each with one fetch stall cycle
        for (int r = 0; r < 2; r++) begin
            step(mk_in(0, 1, P2, 1, 0, 0, 0), ex(S_FLUSH, 0, 0), "b2b_flush");
            step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_FLUSH, 0, 0), "b2b_flush");
            step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_DRAIN, 0, 0), "b2b_drain");
            step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_RESTORE, 0, 0), "b2b_restore");
            step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_REDIRECT, P2, 0), "b2b_redirect");
            step(mk_in(0, 0, 0, 1, 0, 0, 0),  ex(S_REDIRECT, P2, 0), "b2b_stall");
            step(idle_in,                     ex(S_IDLE, 0, 0), "b2b_idle");
        end
`ifdef RECOVERY_PERF_CNT_EN
        n_tests++;
        if (perf_recoveries_o !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_recoveries: got %0d expected 2", perf_recoveries_o);
        end
        n_tests++;
        if (perf_stall_cycles_o !== 32'd12) begin
            n_fail++;
            $display("FAIL perf_stall_cycles: got %0d expected 12", perf_stall_cycles_o);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
